// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the slave side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: SYNC, LEN, LEN*4 payload bytes (MSB first), XOR checksum.
// Writes assembled words to instruction memory and releases cpu_hold only on a good checksum.
module imem_loader #(
  parameter int         ADDR_W    = 8,
  parameter int         BASE_ADDR = 0,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus,
  input  logic         start,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            state_q;
  logic [7:0]        len_q;
  logic [1:0]        bcnt_q;
  logic [7:0]        wcnt_q;
  logic [7:0]        csum_q;
  logic [23:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic              xfer_d;
  logic [31:0]       word_d;
  logic [7:0]        csum_d;
  logic [7:0]        wcnt_d;
  logic [ADDR_W-1:0] addr_d;

  assign xfer_d = bus.in_valid & ready_q;
  assign word_d = {word_q, bus.in_data};
  assign csum_d = csum_q ^ bus.in_data;
  assign wcnt_d = wcnt_q + 8'd1;
  assign addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      bcnt_q  <= 2'd0;
      wcnt_q  <= 8'd0;
      csum_q  <= 8'd0;
      word_q  <= 24'd0;
      addr_q  <= BASE_A;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      ready_q <= 1'b1;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer_d && (bus.in_data == SYNC_BYTE)) begin
            state_q <= S_LEN;
          end
        end
        S_LEN: begin
          if (xfer_d) begin
            len_q   <= bus.in_data;
            csum_q  <= 8'd0;
            bcnt_q  <= 2'd0;
            wcnt_q  <= 8'd0;
            state_q <= (bus.in_data == 8'd0) ? S_CSUM : S_DATA;
          end
        end
        S_DATA: begin
          if (xfer_d) begin
            word_q <= word_d[23:0];
            csum_q <= csum_d;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state_q <= S_WRITE;
              we_q    <= 1'b1;
              wdata_q <= word_d;
              ready_q <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          // Address and count advance only after the strobe cycle, so imem_addr is stable during it.
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          addr_q  <= addr_d;
          wcnt_q  <= wcnt_d;
          state_q <= (wcnt_d == len_q) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (xfer_d) begin
            if (bus.in_data == csum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state_q <= S_IDLE;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= BASE_A;
            bcnt_q  <= 2'd0;
            wcnt_q  <= 8'd0;
            csum_q  <= 8'd0;
            word_q  <= 24'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          hold_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
